// File: rtl/fetch_buffer_pkg.sv
// Shared types and default sizing for the instruction fetch buffer and its
// in-flight metadata queue.
package fetch_buffer_pkg;

  localparam int unsigned FBUF_DEPTH_DEF        = 16;
  localparam int unsigned FBUF_MAX_INFLIGHT_DEF = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fbuf_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        two;
  } fbuf_meta_t;

endpackage

// File: rtl/fetch_meta_fifo.sv
// In-order queue of outstanding ICache fetch descriptors; clear empties it
// in one cycle when the fetch stream is redirected.
module fetch_meta_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FBUF_MAX_INFLIGHT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fbuf_meta_t                   wdata,
  output fbuf_meta_t                   rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fbuf_meta_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular queue of {pc, inst} fed by in-order
// ICache responses. Define FETCH_BUFFER_BYPASS_EN to forward a response
// landing in an empty queue straight to the outputs in the same cycle.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = FBUF_DEPTH_DEF,
  parameter int unsigned MAX_INFLIGHT = FBUF_MAX_INFLIGHT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_fire,
  input  logic [31:0]              req_pc,
  input  logic                     req_two,
  input  logic                     resp_valid,
  input  logic [63:0]              resp_data,
  input  logic                     flush,
  output logic                     can_issue,
  output logic [1:0]               out_valid,
  output logic [31:0]              out_inst0,
  output logic [31:0]              out_inst1,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_pc1,
  input  logic [1:0]               out_pop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned ICNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned DROP_W = $clog2(MAX_INFLIGHT + 2);

  fbuf_meta_t        meta_wdata;
  fbuf_meta_t        meta_rdata;
  logic              meta_push;
  logic              meta_pop;
  logic              meta_empty;
  logic              meta_full;
  logic [ICNT_W-1:0] meta_cnt;

  logic [PTR_W-1:0]  head_q, tail_q, head_n, tail_n, count_n;
  logic [DROP_W-1:0] drop_q, drop_n, drop_old;
  logic [ICNT_W-1:0] inflight_n;
  logic              can_issue_n;
  logic              wr_en;

  fbuf_entry_t       mem [DEPTH];
  fbuf_entry_t       wr_e0, wr_e1, slot0, slot1;
  logic [IDX_W-1:0]  tail_idx0, tail_idx1, head_idx0, head_idx1;
  logic [1:0]        vld;

  assign meta_wdata = '{pc: req_pc, two: req_two};

  fetch_meta_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_meta (
    .clk   (clk),
    .reset (reset),
    .push  (meta_push),
    .pop   (meta_pop),
    .clear (flush),
    .wdata (meta_wdata),
    .rdata (meta_rdata),
    .empty (meta_empty),
    .full  (meta_full),
    .count (meta_cnt)
  );

  assign tail_idx0 = tail_q[IDX_W-1:0];
  assign tail_idx1 = tail_idx0 + IDX_W'(1);
  assign head_idx0 = head_q[IDX_W-1:0];
  assign head_idx1 = head_idx0 + IDX_W'(1);
  assign wr_e0     = '{pc: meta_rdata.pc,          inst: resp_data[31:0]};
  assign wr_e1     = '{pc: meta_rdata.pc + 32'd4,  inst: resp_data[63:32]};
  assign count     = tail_q - head_q;

  // Next-state pointers, drop counter and issue credit.
  always_comb begin
    wr_en      = 1'b0;
    meta_push  = 1'b0;
    meta_pop   = 1'b0;
    head_n     = head_q;
    tail_n     = tail_q;
    drop_n     = drop_q;
    drop_old   = drop_q + DROP_W'(meta_cnt);
    inflight_n = meta_cnt;
    if (flush) begin
      // Everything still unanswered (old drops, in-flight, this cycle's fire)
      // becomes a drop; a response this cycle answers the oldest of them.
      head_n     = tail_q;
      drop_n     = drop_old - DROP_W'(resp_valid && (drop_old != '0)) + DROP_W'(req_fire);
      inflight_n = '0;
    end else begin
      wr_en     = resp_valid && (drop_q == '0) && !meta_empty && !reset;
      meta_pop  = wr_en;
      meta_push = req_fire && !meta_full;
      if (resp_valid && (drop_q != '0)) drop_n = drop_q - DROP_W'(1);
      head_n = head_q + PTR_W'(out_pop);
      if (wr_en) tail_n = tail_q + (meta_rdata.two ? PTR_W'(2) : PTR_W'(1));
      inflight_n = meta_cnt + ICNT_W'(meta_push) - ICNT_W'(meta_pop);
    end
    count_n     = tail_n - head_n;
    can_issue_n = (int'(inflight_n) < int'(MAX_INFLIGHT)) && (drop_n == '0) &&
                  (int'(DEPTH) - int'(count_n) - 2 * int'(inflight_n) >= 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      drop_q    <= '0;
      can_issue <= 1'b0;
    end else begin
      head_q    <= head_n;
      tail_q    <= tail_n;
      drop_q    <= drop_n;
      can_issue <= can_issue_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail_idx0] <= wr_e0;
      if (meta_rdata.two) mem[tail_idx1] <= wr_e1;
    end
  end

  // A response nobody asked for is an upstream protocol error.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(resp_valid && (drop_q == '0) && meta_empty));
  end

  // Output view of the two oldest entries; invalid slots read as zero.
  always_comb begin
    slot0 = mem[head_idx0];
    slot1 = mem[head_idx1];
    vld   = (count > PTR_W'(1)) ? 2'b11 : ((count == PTR_W'(1)) ? 2'b01 : 2'b00);
`ifdef FETCH_BUFFER_BYPASS_EN
    if ((count == '0) && wr_en) begin
      slot0 = wr_e0;
      slot1 = wr_e1;
      vld   = meta_rdata.two ? 2'b11 : 2'b01;
    end
`endif
    out_valid = vld;
    out_inst0 = vld[0] ? slot0.inst : '0;
    out_pc0   = vld[0] ? slot0.pc   : '0;
    out_inst1 = vld[1] ? slot1.inst : '0;
    out_pc1   = vld[1] ? slot1.pc   : '0;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed plus randomized bench for fetch_buffer against a queue-based model.
module tb_fetch_buffer;

  localparam int DEPTH = 16;
  localparam int MAXI  = 2;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct packed { logic [31:0] pc; logic two; } mt_t;

  logic        clk, reset;
  logic        req_fire, req_two, resp_valid, flush;
  logic [31:0] req_pc;
  logic [63:0] resp_data;
  logic [1:0]  out_pop;
  logic        can_issue;
  logic [1:0]  out_valid;
  logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
  logic [$clog2(DEPTH):0] count;

  fetch_buffer #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_pc(req_pc), .req_two(req_two),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush), .can_issue(can_issue),
    .out_valid(out_valid), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_pop(out_pop), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffered instructions, outstanding fetches, drops.
  ent_t q[$];
  mt_t  mq[$];
  int   drop;
  int   wr_total;
  bit   exp_can;
  int   n_cmp, n_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int hidx();
    return (wr_total - q.size()) % DEPTH;
  endfunction

  task automatic model_update(input bit f, input logic [31:0] pc, input bit two,
                              input bit rv, input logic [63:0] rd, input bit fl, input int pop);
    int  old;
    mt_t m;
    if (reset) begin
      q.delete(); mq.delete(); drop = 0; wr_total = 0; exp_can = 0;
      return;
    end
    if (fl) begin
      old  = drop + mq.size();
      drop = old - ((rv && old > 0) ? 1 : 0) + (f ? 1 : 0);
      mq.delete();
      q.delete();
    end else begin
      if (rv) begin
        if (drop > 0) drop--;
        else if (mq.size() > 0) begin
          m = mq.pop_front();
          q.push_back(ent_t'{m.pc, rd[31:0]}); wr_total++;
          if (m.two) begin q.push_back(ent_t'{m.pc + 32'd4, rd[63:32]}); wr_total++; end
        end
      end
      for (int k = 0; k < pop; k++) if (q.size() > 0) q.delete(0);
      if (f) mq.push_back(mt_t'{pc, two});
    end
    exp_can = (mq.size() < MAXI) && (drop == 0) && (DEPTH - q.size() - 2 * mq.size() >= 2);
  endtask

  // One clock: drive at negedge, check outputs, advance model, clock, idle inputs.
  task automatic cyc(input bit f, input logic [31:0] pc, input bit two, input bit rv,
                     input logic [63:0] rd, input bit fl, input int pop);
    ent_t v[$];
    req_fire = f; req_pc = pc; req_two = two; resp_valid = rv;
    resp_data = rd; flush = fl; out_pop = 2'(pop);
    #1;
    v = q;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (!reset && !fl && rv && drop == 0 && mq.size() > 0 && q.size() == 0) begin
      v.push_back(ent_t'{mq[0].pc, rd[31:0]});
      if (mq[0].two) v.push_back(ent_t'{mq[0].pc + 32'd4, rd[63:32]});
    end
`endif
    chk("count", 64'(count), 64'(q.size()));
    chk("can_issue", 64'(can_issue), 64'(exp_can));
    chk("out_valid", 64'(out_valid), (v.size() >= 2) ? 64'd3 : 64'(v.size()));
    if (v.size() >= 1) begin
      chk("out_inst0", 64'(out_inst0), 64'(v[0].inst));
      chk("out_pc0", 64'(out_pc0), 64'(v[0].pc));
    end
    if (v.size() >= 2) begin
      chk("out_inst1", 64'(out_inst1), 64'(v[1].inst));
      chk("out_pc1", 64'(out_pc1), 64'(v[1].pc));
    end
    model_update(f, pc, two, rv, rd, fl, pop);
    @(posedge clk);
    @(negedge clk);
    req_fire = 0; req_pc = '0; req_two = 0; resp_valid = 0;
    resp_data = '0; flush = 0; out_pop = '0;
    #1;
  endtask

  function automatic int min2(input int n);
    return (n > 2) ? 2 : n;
  endfunction

  initial begin
    logic [63:0] d;
    logic [31:0] pc;
    bit f, two, rv, fl;
    int pop;

    n_cmp = 0; n_mis = 0; drop = 0; wr_total = 0; exp_can = 0;
    reset = 1; req_fire = 0; req_pc = '0; req_two = 0; resp_valid = 0;
    resp_data = '0; flush = 0; out_pop = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    cyc(0, '0, 0, 0, '0, 0, 0);
    chk("rst_inst0", 64'(out_inst0), 64'd0);
    chk("rst_pc0", 64'(out_pc0), 64'd0);
    chk("rst_inst1", 64'(out_inst1), 64'd0);
    chk("rst_pc1", 64'(out_pc1), 64'd0);
    chk("rst_can_issue", 64'(can_issue), 64'd0);
    reset = 0;
    cyc(0, '0, 0, 0, '0, 0, 0);
    chk("post_rst_can_issue", 64'(can_issue), 64'd1);

    // Two-slot fetch at the boot vector
    cyc(1, 32'hBFC0_0000, 1, 0, '0, 0, 0);
    cyc(0, '0, 0, 1, 64'h2402_0001_2401_0001, 0, 0);
    chk("boot_valid", 64'(out_valid), 64'd3);
    chk("boot_pc0", 64'(out_pc0), 64'hBFC0_0000);
    chk("boot_pc1", 64'(out_pc1), 64'hBFC0_0004);
    chk("boot_inst0", 64'(out_inst0), 64'h2401_0001);
    chk("boot_inst1", 64'(out_inst1), 64'h2402_0001);
    cyc(0, '0, 0, 0, '0, 0, 2);

    // Single-slot fetch
    cyc(1, 32'h8000_0004, 0, 0, '0, 0, 0);
    cyc(0, '0, 0, 1, 64'h1111_2222_3333_4444, 0, 0);
    chk("single_count", 64'(count), 64'd1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_inst0", 64'(out_inst0), 64'h3333_4444);
    chk("single_pc0", 64'(out_pc0), 64'h8000_0004);
    cyc(0, '0, 0, 0, '0, 0, 1);

    // Fill without popping until credit runs out, then drain across the wrap
    pc = 32'h8000_0100;
    for (int i = 0; i < 64 && (exp_can || mq.size() > 0); i++) begin
      f = exp_can;
      cyc(f, pc, 1, mq.size() > 0, {$urandom, $urandom}, 0, 0);
      if (f) pc = pc + 32'd8;
    end
    chk("fill_count", 64'(count), 64'(DEPTH));
    chk("fill_can_issue", 64'(can_issue), 64'd0);
    for (int i = 0; i < DEPTH && q.size() > 0; i++) cyc(0, '0, 0, 0, '0, 0, min2(q.size()));
    chk("drain_count", 64'(count), 64'd0);

    // Flush with two fetches outstanding; both responses must be dropped
    cyc(1, 32'h8000_0400, 1, 0, '0, 0, 0);
    cyc(1, 32'h8000_0408, 0, 0, '0, 0, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_can_issue", 64'(can_issue), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(0, '0, 0, 1, {$urandom, $urandom}, 0, 0);
    chk("drop1_can_issue", 64'(can_issue), 64'd0);
    cyc(0, '0, 0, 1, {$urandom, $urandom}, 0, 0);
    chk("drop2_can_issue", 64'(can_issue), 64'd1);
    chk("drop2_count", 64'(count), 64'd0);

`ifdef FETCH_BUFFER_BYPASS_EN
    // Same-cycle forwarding into an empty queue with an immediate pop
    cyc(1, 32'h8000_0800, 1, 0, '0, 0, 0);
    cyc(0, '0, 0, 1, 64'hAAAA_0001_BBBB_0002, 0, 1);
    chk("bypass_count", 64'(count), 64'd1);
    chk("bypass_pc0", 64'(out_pc0), 64'h8000_0804);
    cyc(0, '0, 0, 0, '0, 0, 1);
`endif

    // Reset while a fetch is in flight
    cyc(1, 32'h8000_0C00, 1, 0, '0, 0, 0);
    reset = 1;
    cyc(0, '0, 0, 0, '0, 0, 0);
    cyc(0, '0, 0, 0, '0, 0, 0);
    reset = 0;
    cyc(0, '0, 0, 0, '0, 0, 0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_can_issue", 64'(can_issue), 64'd1);

    // Walk head to DEPTH-1, then push 2 / pop 2 in one cycle across the wrap
    for (int i = 0; i < DEPTH + 2 && hidx() != DEPTH - 1; i++) begin
      cyc(1, 32'h8000_1000 + 32'(i * 4), 0, 0, '0, 0, 0);
      cyc(0, '0, 0, 1, {$urandom, $urandom}, 0, 0);
      cyc(0, '0, 0, 0, '0, 0, 1);
    end
    cyc(1, 32'h8000_2000, 1, 0, '0, 0, 0);
    cyc(1, 32'h8000_3000, 1, 1, {$urandom, $urandom}, 0, 0);
    d = {$urandom, $urandom};
    cyc(0, '0, 0, 1, d, 0, 2);
    chk("wrap_count", 64'(count), 64'd2);
    chk("wrap_pc0", 64'(out_pc0), 64'h8000_3000);
    chk("wrap_pc1", 64'(out_pc1), 64'h8000_3004);
    chk("wrap_inst0", 64'(out_inst0), 64'(d[31:0]));
    chk("wrap_inst1", 64'(out_inst1), 64'(d[63:32]));
    cyc(0, '0, 0, 0, '0, 0, 2);

    // Randomized traffic with occasional redirects
    for (int i = 0; i < 1500; i++) begin
      f   = exp_can && ($urandom_range(0, 2) != 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      two = $urandom_range(0, 1) != 0;
      rv  = (mq.size() + drop > 0) && ($urandom_range(0, 2) != 0);
      fl  = $urandom_range(0, 49) == 0;
      pop = ((i % 300) < 80) ? 0 : $urandom_range(0, 2);
      if (pop > q.size()) pop = q.size();
      d   = {$urandom, $urandom};
      cyc(f, pc, two, rv, d, fl, pop);
    end
    for (int i = 0; i < 40 && (q.size() > 0 || mq.size() + drop > 0); i++)
      cyc(0, '0, 0, mq.size() + drop > 0, {$urandom, $urandom}, 0, min2(q.size()));
    chk("final_count", 64'(count), 64'd0);
    chk("final_can_issue", 64'(can_issue), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 16, instruction-entry count; power of two, >=4.
REQ-002 Parameter MAX_INFLIGHT, default 2, maximum outstanding ICache fetches.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_fire  input  1  fetch accepted by ICache this cycle (addr_ok).
REQ-006 req_pc  input  32  PC of slot 0 of the accepted fetch, word aligned.
REQ-007 req_two  input  1  slot 1 (req_pc+4) of the accepted fetch is valid.
REQ-008 resp_valid  input  1  ICache data_ok, in order, one per accepted fetch.
REQ-009 resp_data  input  64  {slot1 inst, slot0 inst}.
REQ-010 flush  input  1  redirect; discard all queued and in-flight instructions.
REQ-011 can_issue  output  1  upstream may assert req_fire next cycle.
REQ-012 out_valid  output  2  bit i: output slot i holds an instruction; bit1 implies bit0.
REQ-013 out_inst0 / out_inst1  output  32 each  oldest / second-oldest instruction.
REQ-014 out_pc0 / out_pc1  output  32 each  PCs of those instructions.
REQ-015 out_pop  input  2  number consumed this cycle (0..2); never exceeds popcount(out_valid).
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 Queue SHALL be a circular buffer with head/tail pointers one bit wider than the index; full when the index bits are equal and the MSBs differ.
REQ-018 On req_fire, {req_pc, req_two} SHALL be pushed to an in-order metadata queue of MAX_INFLIGHT entries.
REQ-019 On resp_valid (not dropped), metadata SHALL pop; slot0 SHALL write at tail, slot1 at tail+1 when req_two; tail advances 1 or 2.
REQ-020 Pops SHALL advance head by out_pop; a push and a pop in the same cycle SHALL both take effect; count = tail-head.
REQ-021 can_issue SHALL equal (inflight < MAX_INFLIGHT) && (DEPTH - count - 2*inflight >= 2), with inflight counted after this cycle's fires and responses; overflow is impossible by construction.
REQ-022 Pointer wrap SHALL be modulo DEPTH; a two-entry push or pop straddling the wrap SHALL be correct.
REQ-023 On flush, the next cycle SHALL show head=tail, out_valid=0, metadata queue empty, and drop_cnt = inflight not answered in the flush cycle (including a req_fire in the flush cycle).
REQ-024 While drop_cnt>0, each resp_valid SHALL decrement drop_cnt and write nothing; can_issue SHALL be 0 while drop_cnt>0.
REQ-025 out_pop and resp_valid in the flush cycle SHALL be ignored.
REQ-026 resp_valid with no inflight request and drop_cnt=0 SHALL be ignored (assertion in simulation).

Reset
REQ-027 On reset: head=tail=0, inflight=0, drop_cnt=0, count=0, out_valid=0, can_issue=0 during reset and 1 the cycle after reset deasserts; out_inst/out_pc SHALL be 0.
REQ-028 Reset mid-fetch SHALL discard in-flight metadata; upstream is reset together, so no drop counting is required.

Configuration
REQ-029 Macro FETCH_BUFFER_BYPASS_EN: when defined, an instruction written while the queue is empty SHALL appear on out_* in the same cycle (combinational from resp_data) and may be popped that cycle; when undefined, latency from resp_valid to out_valid SHALL be exactly one cycle.

Structure
REQ-030 Shared package SHALL hold fbuf_entry_t {pc, inst}, fbuf_meta_t {pc, two}, and the DEPTH/MAX_INFLIGHT defaults.
REQ-031 The metadata queue SHALL be a sub-module, fetch_meta_fifo (parameterised depth, push/pop/clear, empty/full).

Verification
REQ-032 Reset, fire pc=0xBFC00000 two=1, resp 0x24020001_24010001 -> next cycle out_valid=2'b11, pc0=0xBFC00000, pc1=0xBFC00004 (bypass off).
REQ-033 Fire pc=0x80000004 two=0 -> single entry written; out_inst1 never driven valid for it; count=1.
REQ-034 Fill with no pops until can_issue=0 -> count reaches DEPTH-2*inflight exactly; no entry lost; pop 2/cycle drains in FIFO order across wrap.
REQ-035 Two fires outstanding, flush -> next cycle count=0, can_issue=0; both later responses dropped; can_issue=1 after the second.
REQ-036 Push 2 and pop 2 in the same cycle at head index DEPTH-1 -> count unchanged, order preserved.
REQ-037 With FETCH_BUFFER_BYPASS_EN, response into empty queue, out_pop=1 same cycle -> out_valid=2'b11 that cycle, count=1 next cycle.
